// File: rtl/mont_operand_loader.sv
// Word-serial operand loader / result unloader in front of the 512-bit Montgomery multiplier.
// Optional WAIT watchdog enabled by defining MONT_LOADER_TIMEOUT_EN.
module mont_operand_loader #(
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned OP_W           = 512,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [OP_W-1:0]   mont_a,
  output logic [OP_W-1:0]   mont_b,
  output logic [OP_W-1:0]   mont_m,
  output logic              mont_start,
  input  logic [OP_W-1:0]   mont_result,
  input  logic              mont_done,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              err
);

  localparam int unsigned N      = OP_W / WORD_W;
  localparam int unsigned IN_CW  = 6;
  localparam int unsigned OUT_CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(3 * N - 1);
  localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(N - 1);

  // Counter bits [5:4] select the target operand, which fixes N at 16 words.
  if (OP_W != 16 * WORD_W || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("mont_operand_loader: OP_W must be 16*WORD_W and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IN_CW-1:0]    r_in_cnt;
  logic [OUT_CW-1:0]   r_out_cnt;
  logic [OP_W-1:0]     r_a;
  logic [OP_W-1:0]     r_b;
  logic [OP_W-1:0]     r_m;
  logic [OP_W-1:0]     r_res;
  logic [N-1:0][WORD_W-1:0] w_res_words;
  logic                w_in_acc;
  logic                w_out_acc;
  logic                w_timeout;

  assign w_in_acc    = (r_state == ST_LOAD) && s_valid;
  assign w_out_acc   = (r_state == ST_UNLOAD) && m_ready;
  assign w_res_words = r_res;

  assign mont_a = r_a;
  assign mont_b = r_b;
  assign mont_m = r_m;
  assign m_data = w_res_words[r_out_cnt];

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_LOAD;
    else         r_state <= w_state_nxt;
  end

  // Next state and state-decoded handshake/control outputs
  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    mont_start  = 1'b0;
    m_valid     = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_LOAD: begin
        s_ready = 1'b1;
        if (s_valid && r_in_cnt == IN_LAST) w_state_nxt = ST_START;
      end
      ST_START: begin
        mont_start  = 1'b1;
        busy        = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (mont_done)      w_state_nxt = ST_UNLOAD;
        else if (w_timeout) w_state_nxt = ST_LOAD;
      end
      ST_UNLOAD: begin
        m_valid = 1'b1;
        busy    = 1'b1;
        if (m_ready && r_out_cnt == OUT_LAST) w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // Operand packing, result capture and word counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_m       <= '0;
      r_res     <= '0;
    end else begin
      if (w_in_acc) begin
        case (r_in_cnt[5:4])
          2'd0:    r_a <= {s_data, r_a[OP_W-1:WORD_W]};
          2'd1:    r_b <= {s_data, r_b[OP_W-1:WORD_W]};
          2'd2:    r_m <= {s_data, r_m[OP_W-1:WORD_W]};
          default: ;
        endcase
        r_in_cnt <= (r_in_cnt == IN_LAST) ? '0 : r_in_cnt + IN_CW'(1);
      end
      if (r_state == ST_WAIT && mont_done) r_res <= mont_result;
      if (w_out_acc) r_out_cnt <= (r_out_cnt == OUT_LAST) ? '0 : r_out_cnt + OUT_CW'(1);
    end
  end

`ifdef MONT_LOADER_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  // A done arriving on the expiry cycle wins over the timeout.
  assign w_timeout = (r_state == ST_WAIT) && !mont_done && (r_to_cnt == TO_LAST);
  assign err       = r_err;

  // WAIT watchdog, cleared whenever WAIT is not active
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == ST_WAIT && !mont_done && !w_timeout) r_to_cnt <= r_to_cnt + TO_W'(1);
      else                                                r_to_cnt <= '0;
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

endmodule
